alu_op_sequencer: RTL and testbench

Command sequencer sitting directly upstream of the 12-bit ALU. It accepts ALU commands over a valid/ready stream, reads operands from a 4-entry x 12-bit register file or an immediate, and drives the ALU's A, B and OP inputs from registers. It captures the ALU's Z, Cout, Sign and OV one cycle later, writes Z back to the destination register, and returns the result and flags over a second valid/ready stream.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq_regfile.sv | 35 +++
 rtl/alu_op_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, default sizes and FSM state type
// shared by the ALU command sequencer files.
package alu_seq_pkg;

  localparam int W_DEF    = 12;
  localparam int NREG_DEF = 4;

  localparam logic [2:0] SHR_A = 3'd0;
  localparam logic [2:0] SHL_B = 3'd1;
  localparam logic [2:0] AND   = 3'd2;
  localparam logic [2:0] OR    = 3'd3;
  localparam logic [2:0] XOR   = 3'd4;
  localparam logic [2:0] NOT_A = 3'd5;
  localparam logic [2:0] ADD   = 3'd6;
  localparam logic [2:0] SUB   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREG x W operand store, two async
// read ports, one sync write port, async clear.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [W-1:0]            wdata,
  input  logic [$clog2(NREG)-1:0] raddr_a,
  output logic [W-1:0]            rdata_a,
  input  logic [$clog2(NREG)-1:0] raddr_b,
  output logic [W-1:0]            rdata_b
);

  logic [W-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: serial issue of ALU commands with writeback.
// Optional sticky overflow flag via ALU_SEQ_STICKY_OV_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_ra,
  input  logic [$clog2(NREG)-1:0] cmd_rb,
  input  logic [$clog2(NREG)-1:0] cmd_rd,
  input  logic                    cmd_imm_en,
  input  logic [W-1:0]            cmd_imm,
  output logic [W-1:0]            alu_a,
  output logic [W-1:0]            alu_b,
  output logic [2:0]              alu_op,
  input  logic [W-1:0]            alu_z,
  input  logic                    alu_cout,
  input  logic                    alu_sign,
  input  logic                    alu_ov,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [W-1:0]            res_data,
  output logic                    res_c,
  output logic                    res_s,
  output logic                    res_v,
  output logic                    ov_sticky,
  input  logic                    ov_clr
);

  localparam int RW = $clog2(NREG);

  state_t       state;
  logic [RW-1:0] rd_q;
  logic [W-1:0]  rf_a;
  logic [W-1:0]  rf_b;
  logic          arith;

  alu_seq_regfile #(
    .W    (W),
    .NREG (NREG)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (state == ISSUE),
    .waddr   (rd_q),
    .wdata   (alu_z),
    .raddr_a (cmd_ra),
    .rdata_a (rf_a),
    .raddr_b (cmd_rb),
    .rdata_b (rf_b)
  );

  assign cmd_ready = (state == IDLE);
  // carry and overflow only mean something for add/subtract
  assign arith = (alu_op == ADD) || (alu_op == SUB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_q      <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_c     <= 1'b0;
      res_s     <= 1'b0;
      res_v     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_a  <= rf_a;
            alu_b  <= cmd_imm_en ? cmd_imm : rf_b;
            alu_op <= cmd_op;
            rd_q   <= cmd_rd;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          res_data  <= alu_z;
          res_s     <= alu_sign;
          res_c     <= arith & alu_cout;
          res_v     <= arith & alu_ov;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_OV_EN
  // a new overflow beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_sticky <= 1'b0;
    end else if (state == ISSUE && arith && alu_ov) begin
      ov_sticky <= 1'b1;
    end else if (ov_clr) begin
      ov_sticky <= 1'b0;
    end
  end
`else
  logic unused_ov_clr;
  assign unused_ov_clr = ov_clr;
  assign ov_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed table, corner sequences and
// random commands against an ALU stub and a reference model.
module tb_alu_op_sequencer;

  localparam int W = 12;

  typedef struct packed {
    logic         v;
    logic         s;
    logic         c;
    logic [W-1:0] z;
  } alu_res_t;

  typedef struct {
    logic [2:0]   op;
    logic [1:0]   ra;
    logic [1:0]   rb;
    logic [1:0]   rd;
    logic         ie;
    logic [W-1:0] imm;
    logic [W-1:0] ed;
    logic         ec;
    logic         es;
    logic         ev;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [1:0]   cmd_ra = '0;
  logic [1:0]   cmd_rb = '0;
  logic [1:0]   cmd_rd = '0;
  logic         cmd_imm_en = 1'b0;
  logic [W-1:0] cmd_imm = '0;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_z;
  logic         alu_cout;
  logic         alu_sign;
  logic         alu_ov;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         res_c;
  logic         res_s;
  logic         res_v;
  logic         ov_sticky;
  logic         ov_clr = 1'b0;

  int           nchecks = 0;
  int           nerrors = 0;
  logic [W-1:0] rf_m [4];
  logic         sticky_m = 1'b0;
  vec_t         tv [4];

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_ra     (cmd_ra),
    .cmd_rb     (cmd_rb),
    .cmd_rd     (cmd_rd),
    .cmd_imm_en (cmd_imm_en),
    .cmd_imm    (cmd_imm),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_z      (alu_z),
    .alu_cout   (alu_cout),
    .alu_sign   (alu_sign),
    .alu_ov     (alu_ov),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_c      (res_c),
    .res_s      (res_s),
    .res_v      (res_v),
    .ov_sticky  (ov_sticky),
    .ov_clr     (ov_clr)
  );

  // ALU stub; logic ops raise C and V so masking is visible
  function automatic alu_res_t alu_f(input logic [2:0] op,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    alu_res_t   r;
    logic [W:0] t;
    r.z = '0;
    r.c = 1'b1;
    r.v = 1'b1;
    case (op)
      3'd0: r.z = a >> 1;
      3'd1: r.z = b << 1;
      3'd2: r.z = a & b;
      3'd3: r.z = a | b;
      3'd4: r.z = a ^ b;
      3'd5: r.z = ~a;
      3'd6: begin
        t   = {1'b0, a} + {1'b0, b};
        r.z = t[W-1:0];
        r.c = t[W];
        r.v = (a[W-1] == b[W-1]) && (r.z[W-1] != a[W-1]);
      end
      default: begin
        r.z = a - b;
        r.c = a < b;
        r.v = a < b;
      end
    endcase
    r.s = r.z[W-1];
    return r;
  endfunction

  alu_res_t ar;
  assign ar       = alu_f(alu_op, alu_a, alu_b);
  assign alu_z    = ar.z;
  assign alu_cout = ar.c;
  assign alu_sign = ar.s;
  assign alu_ov   = ar.v;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock edge; mode 0 no clear, 1 random clear, 2 clear held
  task automatic step(input int mode, input logic setv);
    ov_clr = (mode == 2) ? 1'b1 :
             (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk);
`ifdef ALU_SEQ_STICKY_OV_EN
    if (setv) sticky_m = 1'b1;
    else if (ov_clr) sticky_m = 1'b0;
`else
    sticky_m = 1'b0 & setv;
`endif
    #1;
    ov_clr = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [1:0] rd,
                         input logic ie, input logic [W-1:0] imm,
                         input int dly, input bit keepv, input int mode,
                         output logic [W-1:0] gd, output logic gc,
                         output logic gs, output logic gv);
    logic [W-1:0] a;
    logic [W-1:0] b;
    alu_res_t     r;
    logic         arith;
    a     = rf_m[ra];
    b     = ie ? imm : rf_m[rb];
    r     = alu_f(op, a, b);
    arith = (op == 3'd6) || (op == 3'd7);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_op     = op;
    cmd_ra     = ra;
    cmd_rb     = rb;
    cmd_rd     = rd;
    cmd_imm_en = ie;
    cmd_imm    = imm;
    cmd_valid  = 1'b1;
    if (mode == 1) res_ready = 1'($urandom_range(0, 1));
    step(mode, 1'b0);
    if (!keepv) cmd_valid = 1'b0;
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("alu_op", alu_op, op);
    chk("cmd_ready_issue", cmd_ready, 0);
    chk("res_valid_issue", res_valid, 0);
    step(mode, arith & r.v);
    rf_m[rd] = r.z;
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, r.z);
    chk("res_c", res_c, arith & r.c);
    chk("res_s", res_s, r.s);
    chk("res_v", res_v, arith & r.v);
    chk("ov_sticky_resp", ov_sticky, sticky_m);
    gd = res_data;
    gc = res_c;
    gs = res_s;
    gv = res_v;
    res_ready = (dly == 0);
    for (int i = 0; i < dly; i++) begin
      step(mode, 1'b0);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, r.z);
      chk("hold_flags", {res_c, res_s, res_v},
          {arith & r.c, r.s, arith & r.v});
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_alu_a", alu_a, a);
      chk("hold_alu_op", alu_op, op);
    end
    res_ready = 1'b1;
    step(mode, 1'b0);
    chk("res_valid_done", res_valid, 0);
    chk("cmd_ready_done", cmd_ready, 1);
    chk("ov_sticky_done", ov_sticky, sticky_m);
  endtask

  initial begin
    logic [W-1:0] gd;
    logic         gc;
    logic         gs;
    logic         gv;

    tv[0] = '{op: 3'd3, ra: 2'd0, rb: 2'd0, rd: 2'd1, ie: 1'b1,
              imm: 12'h7FF, ed: 12'h7FF, ec: 1'b0, es: 1'b0, ev: 1'b0};
    tv[1] = '{op: 3'd6, ra: 2'd1, rb: 2'd0, rd: 2'd2, ie: 1'b1,
              imm: 12'h001, ed: 12'h800, ec: 1'b0, es: 1'b1, ev: 1'b1};
    tv[2] = '{op: 3'd7, ra: 2'd0, rb: 2'd0, rd: 2'd3, ie: 1'b1,
              imm: 12'h001, ed: 12'hFFF, ec: 1'b1, es: 1'b1, ev: 1'b1};
    tv[3] = '{op: 3'd2, ra: 2'd3, rb: 2'd1, rd: 2'd0, ie: 1'b0,
              imm: 12'h000, ed: 12'h7FF, ec: 1'b0, es: 1'b0, ev: 1'b0};
    for (int i = 0; i < 4; i++) rf_m[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_ov_sticky", ov_sticky, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      run_cmd(tv[i].op, tv[i].ra, tv[i].rb, tv[i].rd, tv[i].ie,
              tv[i].imm, 0, 1'b0, 0, gd, gc, gs, gv);
      chk("tv_data", gd, tv[i].ed);
      chk("tv_flags", {gc, gs, gv}, {tv[i].ec, tv[i].es, tv[i].ev});
    end

`ifdef ALU_SEQ_STICKY_OV_EN
    chk("sticky_after_ov", ov_sticky, 1);
`else
    chk("sticky_after_ov", ov_sticky, 0);
`endif
    ov_clr = 1'b1;
    @(posedge clk);
    #1;
    ov_clr   = 1'b0;
    sticky_m = 1'b0;
    chk("sticky_cleared", ov_sticky, 0);

    // backpressure: next command held on cmd_valid throughout
    run_cmd(3'd4, 2'd1, 2'd2, 2'd3, 1'b0, 12'h000, 5, 1'b1, 0,
            gd, gc, gs, gv);
    run_cmd(3'd4, 2'd1, 2'd2, 2'd3, 1'b0, 12'h000, 0, 1'b0, 0,
            gd, gc, gs, gv);

    // reset landing in ISSUE discards the writeback
    cmd_op     = 3'd3;
    cmd_ra     = 2'd0;
    cmd_rd     = 2'd1;
    cmd_imm_en = 1'b1;
    cmd_imm    = 12'h123;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rst       = 1'b1;
    #1;
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_alu_a", alu_a, 0);
    chk("midrst_alu_op", alu_op, 0);
    chk("midrst_sticky", ov_sticky, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) rf_m[i] = '0;
    sticky_m = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_res_valid", res_valid, 0);
    chk("postrst_cmd_ready", cmd_ready, 1);
    run_cmd(3'd3, 2'd1, 2'd0, 2'd2, 1'b1, 12'h000, 0, 1'b0, 0,
            gd, gc, gs, gv);
    chk("rf1_after_rst", gd, 0);

    // overflow set beats a clear held across the issue edge
    run_cmd(3'd3, 2'd0, 2'd0, 2'd0, 1'b1, 12'h7FF, 0, 1'b0, 0,
            gd, gc, gs, gv);
    run_cmd(3'd6, 2'd0, 2'd0, 2'd1, 1'b1, 12'h001, 1, 1'b0, 2,
            gd, gc, gs, gv);

    for (int n = 0; n < 200; n++) begin
      run_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 12'($urandom),
              $urandom_range(0, 3), 1'b0, 1, gd, gc, gs, gv);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end

endmodule
